max7219_emu: RTL
================

# max7219_emu

SPI responder that emulates a MAX7219 8-digit LED controller. Receives the 16-bit address/data frames sent by the team's `max7219` driver (`max_din`, `max_clk`, `ce_` as load) and stores them in an internal register file. Drives a multiplexed common-cathode 8-digit 7-segment display with scan, intensity PWM, shutdown, display test and optional Code-B decode. Used as a drop-in target on boards without the real chip and as a loopback checker for the driver.

## Interface
- `SCAN_DIV`, 16: sysclk cycles per PWM step; one digit slot = 32 × `SCAN_DIV` cycles.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `max_din`  in  1  serial data, MSB first; asynchronous to `clk`.
- `max_clk`  in  1  serial clock; data sampled on its rising edge.
- `ce_`  in  1  load: low during shifting, rising edge latches frame.
- `seg`  out  8  segments, active high: [7]=DP, [6:0]=A..G.
- `dig_n`  out  8  digit selects, active low; `dig_n[k]` = digit register k+1.
- `frame_valid`  out  1  one-cycle pulse when a frame is latched.
- `frame_err`  out  1  one-cycle pulse when `ce_` rises after fewer than 16 bits.

## Operation
- Inputs pass through 2-flop synchronizers, then edge detectors. `max_clk` high and low phases must each be ≥3 `clk` cycles.
- Shifting: on a synced `max_clk` rise while synced `ce_` is low, a 16-bit shift register takes `max_din` at the LSB. A 5-bit bit counter saturates at 16. A synced `ce_` fall clears the counter. `max_clk` edges while `ce_` is high are ignored.
- Latch: on a synced `ce_` rise:
  - counter ≥16: use the last 16 bits shifted; addr = bits[11:8], data = bits[7:0]; pulse `frame_valid`.
  - otherwise: discard the frame, pulse `frame_err`, leave registers unchanged.
- Register map:
  - 0 = no-op.
  - 1–8 = digit RAM.
  - 9 = decode mode (bit k ↔ digit k+1).
  - 0xA = intensity[3:0].
  - 0xB = scan limit[2:0].
  - 0xC = shutdown (bit0: 0 = shutdown, 1 = normal).
  - 0xF = display test (bit0).
  - 0xD, 0xE = no-op, but still pulse `frame_valid`.
- Reset: all registers 0, so the display starts in shutdown.
- Scan FSM states:
  - SHUTDOWN: `dig_n`=FF, `seg`=00. Registers stay writable.
  - SCAN: the digit index cycles 0..scan_limit; each slot has 32 PWM steps of `SCAN_DIV` cycles. The active digit's `dig_n` bit is low for the whole slot. `seg` = digit pattern while step < 2·intensity+1, else 00.
  - TEST: index cycles 0..7 regardless of scan limit, `seg`=FF at every step.
- State transitions are evaluated every cycle: display test = 1 → TEST (overrides shutdown); else shutdown = 0 → SHUTDOWN; else SCAN. Entering SCAN or TEST from SHUTDOWN starts at index 0, step 0.
- Scan-limit change mid-scan: the current slot completes. If the index is then ≥ the new limit, it wraps to 0.
- Digit pattern: raw register byte, or the Code-B font when decode is enabled (see Configuration).

## Timing
- Reset values: `seg`=00, `dig_n`=FF, `frame_valid`=0, `frame_err`=0. Counters, shift register and all registers are 0.
- Pin-to-detect latency: 3 `clk` (2 sync flops + edge register).
- Register write and `frame_valid`/`frame_err` occur in the cycle after `ce_`-rise detection, 4 `clk` after the pin edge. The new value affects `seg` from the next cycle.
- If `max_clk` rise and `ce_` rise are detected in the same cycle, that bit is shifted first and is included in the latched frame.
- `seg` and `dig_n` are registered outputs, 1 cycle after the scan counters.
- Reset asserted mid-frame: the partial frame is lost. After release, the first `ce_` rise yields `frame_err` unless a fresh `ce_` fall plus 16 bits has occurred.

## Configuration
- `MAX7219_CODEB_EN` defined: for digits whose decode bit is set, data[3:0] maps through the Code-B font to A..G. Font values: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=01 ('-'), B=4F (E), C=37 (H), D=0E (L), E=67 (P), F=00 (blank). DP comes from data[7].
- Not defined: the decode register is stored but ignored; all digits display the raw register byte.

## Test plan
- Reset, write 0xC=01, 0xB=07, 0xA=0F, digit 1 = 0x7E → `dig_n[0]` low for 512 cycles, `seg`=7E for 31 of its 32 steps (step 31 → 00), `frame_valid` pulses 4 times.
- Send 12 bits then raise `ce_` → `frame_err` pulse, no register change. Send 20 bits ending in 0x0A05 → intensity=5, so `seg` is on for 11 of 32 steps.
- Write 0xB=02 during scan at index 5 → index wraps to 0 after the slot; only `dig_n[2:0]` go low thereafter.
- Write 0xF=01 while shutdown=0 → all 8 digits scanned with `seg`=FF. Write 0xF=00 → `dig_n`=FF, `seg`=00.
- With `MAX7219_CODEB_EN`: 0x09=01, digit 1 = 0x83 → `seg`=F9. Without the macro → `seg`=83.
- Assert `rst` mid-frame after 8 bits → outputs return to reset values immediately. A following complete frame latches correctly.

Source files
------------

// File: rtl/max7219_emu.sv
// ---------------------------------------------------------------------------
// max7219_emu
//
// SPI responder that behaves like a MAX7219 8-digit LED controller. It takes
// the 16-bit address/data frames produced by the max7219 driver, keeps them
// in an internal register file and drives a multiplexed common-cathode
// 8-digit 7-segment display (scan, intensity PWM, shutdown, display test).
//
// Optional feature: define MAX7219_CODEB_EN to enable Code-B font decoding
// for digits whose decode-mode bit is set. Without it the decode register is
// stored but every digit shows its raw register byte.
//
// Parameters
//   SCAN_DIV     sysclk cycles per PWM step (one digit slot = 32*SCAN_DIV)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   max_din      serial data, MSB first (async to clk)
//   max_clk      serial clock, data taken on its rising edge (async to clk)
//   ce_          load: low while shifting, rising edge latches the frame
//   seg[7:0]     segments, active high, [7]=DP, [6:0]=A..G (registered)
//   dig_n[7:0]   digit selects, active low, bit k = digit register k+1
//   frame_valid  one-cycle pulse when a complete frame is latched
//   frame_err    one-cycle pulse when ce_ rises after fewer than 16 bits
// ---------------------------------------------------------------------------
module max7219_emu #(
    parameter int SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       max_din,
    input  logic       max_clk,
    input  logic       ce_,
    output logic [7:0] seg,
    output logic [7:0] dig_n,
    output logic       frame_valid,
    output logic       frame_err
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_SHUTDOWN = 2'd0,
        ST_SCAN     = 2'd1,
        ST_TEST     = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizers and registered edge detectors
    // -----------------------------------------------------------------------
    logic [1:0] r_din_sync;
    logic [1:0] r_clk_sync;
    logic [1:0] r_ce_sync;
    logic       r_clk_d;
    logic       r_ce_d;
    logic       r_clk_rise;
    logic       r_ce_rise;
    logic       r_ce_fall;
    logic       r_ce_lvl;    // ce_ level before the edge now being reported
    logic       r_din_q;     // data aligned with r_clk_rise

    // The ce_ path resets to its idle (high) level so that releasing reset
    // with ce_ idle never looks like a load edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_sync <= 2'b00;
            r_clk_sync <= 2'b00;
            r_ce_sync  <= 2'b11;
            r_clk_d    <= 1'b0;
            r_ce_d     <= 1'b1;
            r_clk_rise <= 1'b0;
            r_ce_rise  <= 1'b0;
            r_ce_fall  <= 1'b0;
            r_ce_lvl   <= 1'b1;
            r_din_q    <= 1'b0;
        end else begin
            r_din_sync <= {r_din_sync[0], max_din};
            r_clk_sync <= {r_clk_sync[0], max_clk};
            r_ce_sync  <= {r_ce_sync[0], ce_};
            r_clk_d    <= r_clk_sync[1];
            r_ce_d     <= r_ce_sync[1];
            r_clk_rise <= r_clk_sync[1] & ~r_clk_d;
            r_ce_rise  <= r_ce_sync[1] & ~r_ce_d;
            r_ce_fall  <= ~r_ce_sync[1] & r_ce_d;
            r_ce_lvl   <= r_ce_d;
            r_din_q    <= r_din_sync[1];
        end
    end

    // -----------------------------------------------------------------------
    // Shift register, bit counter and register file
    // -----------------------------------------------------------------------
    logic [15:0] r_sr;
    logic [4:0]  r_cnt;
    logic [7:0]  r_digit [0:7];
    logic [7:0]  r_decode;
    logic [3:0]  r_intensity;
    logic [2:0]  r_limit;
    logic        r_normal;   // shutdown register bit0: 1 = normal operation
    logic        r_test;

    logic        w_shift;
    logic [15:0] w_sr_next;
    logic [4:0]  w_cnt_next;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;
    logic [2:0]  w_didx;
    logic        w_full;

    // A max_clk rise reported together with the ce_ rise still sees ce_ low
    // through r_ce_lvl, so that last bit is shifted and lands in the frame.
    assign w_shift    = r_clk_rise & ~r_ce_lvl;
    assign w_sr_next  = w_shift ? {r_sr[14:0], r_din_q} : r_sr;
    assign w_addr     = w_sr_next[11:8];
    assign w_data     = w_sr_next[7:0];
    assign w_didx     = 3'(w_addr - 4'd1);
    assign w_full     = (w_cnt_next == 5'd16);

    always_comb begin
        w_cnt_next = r_cnt;
        if (r_ce_fall)
            w_cnt_next = 5'd0;
        else if (w_shift && r_cnt != 5'd16)
            w_cnt_next = r_cnt + 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            for (int i = 0; i < 8; i++) r_digit[i] <= '0;
            r_decode    <= '0;
            r_intensity <= '0;
            r_limit     <= '0;
            r_normal    <= 1'b0;
            r_test      <= 1'b0;
        end else begin
            r_sr        <= w_sr_next;
            r_cnt       <= w_cnt_next;
            frame_valid <= r_ce_rise & w_full;
            frame_err   <= r_ce_rise & ~w_full;
            if (r_ce_rise && w_full) begin
                case (w_addr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: r_digit[w_didx] <= w_data;
                    4'h9: r_decode    <= w_data;
                    4'hA: r_intensity <= w_data[3:0];
                    4'hB: r_limit     <= w_data[2:0];
                    4'hC: r_normal    <= w_data[0];
                    4'hF: r_test      <= w_data[0];
                    default: ;  // 0x0, 0xD, 0xE: no-op
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Digit pattern (optional Code-B decode)
    // -----------------------------------------------------------------------
    logic [2:0] r_idx;
    logic [7:0] w_raw;
    logic [7:0] w_pat;

    assign w_raw = r_digit[r_idx];

`ifdef MAX7219_CODEB_EN
    function automatic logic [6:0] codeb(input logic [3:0] v);
        logic [6:0] f;
        case (v)
            4'h0: f = 7'h7E;
            4'h1: f = 7'h30;
            4'h2: f = 7'h6D;
            4'h3: f = 7'h79;
            4'h4: f = 7'h33;
            4'h5: f = 7'h5B;
            4'h6: f = 7'h5F;
            4'h7: f = 7'h70;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h7B;
            4'hA: f = 7'h01;  // '-'
            4'hB: f = 7'h4F;  // 'E'
            4'hC: f = 7'h37;  // 'H'
            4'hD: f = 7'h0E;  // 'L'
            4'hE: f = 7'h67;  // 'P'
            default: f = 7'h00;  // blank
        endcase
        return f;
    endfunction

    assign w_pat = r_decode[r_idx] ? {w_raw[7], codeb(w_raw[3:0])} : w_raw;
`else
    // Decode register is kept readable-by-nothing in this build.
    logic w_unused_decode;
    assign w_unused_decode = ^r_decode;
    assign w_pat = w_raw;
`endif

    // -----------------------------------------------------------------------
    // Scan FSM: state + PWM divider/step/digit counters
    // -----------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_next;
    logic [4:0]  r_step;
    logic [4:0]  w_step_next;
    logic [2:0]  w_idx_next;
    logic        w_on;
    logic [7:0]  w_seg;
    logic [7:0]  w_dig_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SHUTDOWN;
            r_div   <= '0;
            r_step  <= '0;
            r_idx   <= '0;
            seg     <= 8'h00;
            dig_n   <= 8'hFF;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_step  <= w_step_next;
            r_idx   <= w_idx_next;
            seg     <= w_seg;
            dig_n   <= w_dig_n;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_step_next  = r_step;
        w_idx_next   = r_idx;

        if (r_test)
            w_state_next = ST_TEST;
        else if (!r_normal)
            w_state_next = ST_SHUTDOWN;
        else
            w_state_next = ST_SCAN;

        // Counters idle at zero in shutdown, so leaving it starts at slot 0.
        if (r_state == ST_SHUTDOWN || w_state_next == ST_SHUTDOWN) begin
            w_div_next  = '0;
            w_step_next = '0;
            w_idx_next  = '0;
        end else if (r_div == DIV_MAX) begin
            w_div_next  = '0;
            w_step_next = r_step + 5'd1;
            if (r_step == 5'd31) begin
                // Slot boundary: a lowered scan limit takes effect here.
                if (w_state_next == ST_TEST)
                    w_idx_next = r_idx + 3'd1;
                else
                    w_idx_next = (r_idx >= r_limit) ? 3'd0 : r_idx + 3'd1;
            end
        end else begin
            w_div_next = r_div + DW'(1);
        end
    end

    // Duty: on for steps 0 .. 2*intensity.
    assign w_on = ({1'b0, r_step} < {1'b0, r_intensity, 1'b1});

    always_comb begin
        w_seg   = 8'h00;
        w_dig_n = 8'hFF;
        case (r_state)
            ST_SCAN: begin
                w_dig_n = ~(8'd1 << r_idx);
                w_seg   = w_on ? w_pat : 8'h00;
            end
            ST_TEST: begin
                w_dig_n = ~(8'd1 << r_idx);
                w_seg   = 8'hFF;
            end
            default: ;
        endcase
    end

endmodule
